// File: rtl/karatsuba_mul_sequencer.sv
// Sequencer around iterative_karatsuba_32_16: operand FIFO, per-op reset pulse plus counted
// enable window, and a valid/ready product register.
module karatsuba_mul_sequencer #(
  parameter int DEPTH       = 2,
  parameter int MUL_LATENCY = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             mul_rst,
  output logic             mul_enable,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_c,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic             mul_enable_q, mul_enable_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic             push_s;
  logic             pop_s;
  logic             handoff_s;
  logic             out_free_s;
  logic             capture_s;

  assign handoff_s  = out_valid_q & out_ready;
  assign out_free_s = ~out_valid_q | out_ready;
  assign push_s     = in_valid & in_ready_q;

  // Sequencing FSM: issue, reset pulse, enable window, and product capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && out_free_s) begin
          pop_s   = 1'b1;
          mul_a_d = mem_q[rd_ptr_q][63:32];
          mul_b_d = mem_q[rd_ptr_q][31:0];
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_LATENCY - 1)) begin
          state_d = CAPTURE;
        end else begin
          state_d = RUN;
        end
      end
      CAPTURE, HOLD: begin
        // The multiplier is not enabled here, so mul_c stays frozen while parked in HOLD.
        if (out_free_s) begin
          capture_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register, hand-off counter and registered status outputs.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (capture_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mul_c;
    end else if (handoff_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (handoff_s) begin
      ops_done_d = ops_done_q + CNT_W'(1);
    end else begin
      ops_done_d = ops_done_q;
    end
    mul_enable_d = (state_d == RUN);
    in_ready_d   = (count_d != (AW + 1)'(DEPTH));
    busy_d       = (state_d != IDLE) | (count_d != '0);
  end

  // Operand FIFO: write port, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {in_a, in_b};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register for FSM, datapath and FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'h0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 64'h0;
      mul_a_q      <= 32'h0;
      mul_b_q      <= 32'h0;
      mul_enable_q <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_enable_q <= mul_enable_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // The multiplier must see reset both during system reset and for the one LOAD cycle.
  assign mul_rst    = rst | (state_q == LOAD);
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_enable = mul_enable_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_karatsuba_mul_sequencer.sv
// Randomized bench for karatsuba_mul_sequencer with a behavioural iterative multiplier and
// a product scoreboard derived from a*b of every accepted operand pair.
module tb_karatsuba_mul_sequencer;

  localparam int CNT_W = 4;
  localparam int LAT   = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             mul_rst;
  logic             mul_enable;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_c;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  karatsuba_mul_sequencer #(.DEPTH(2), .MUL_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .mul_rst(mul_rst),
    .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .busy(busy),
    .ops_done(ops_done)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          m_cnt = 0;
  logic [63:0] exp_q[$];
  int          hs_times[$];
  logic        held = 1'b0;
  logic [63:0] held_data = 64'h0;
  logic        saw_wrap = 1'b0;
  logic        stalled = 1'b0;
  logic        rand_bp = 1'b0;
  logic [3:0]  prev_ops = 4'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Iterative multiplier stand-in: exact only after exactly LAT enabled edges following reset.
  always @(posedge clk) begin
    if (mul_rst) begin
      m_cnt <= 0;
      mul_c <= 64'h0;
    end else if (mul_enable) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) mul_c <= 64'(mul_a) * 64'(mul_b);
      else                  mul_c <= {$urandom(), $urandom()};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else stalled = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !out_valid) done = 1'b1;
      else tick();
    end
    check("drain", 64'(done), 64'd1);
    tick();
  endtask

  // Scoreboard: records accepted pairs, checks hand-offs in order, hold stability and ops_done.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hs_count = 0;
        held = 1'b0;
        check("rst_mul_rst", 64'(mul_rst), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ops_done", 64'(ops_done), 64'd0);
      end else begin
        check("ops_done", 64'(ops_done), 64'(hs_count % 16));
        if (prev_ops == 4'hF && ops_done == 4'h0) saw_wrap = 1'b1;
        if (held) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", out_data, held_data);
        end
        if (in_valid && in_ready) exp_q.push_back(64'(in_a) * 64'(in_b));
        if (out_valid) begin
          if (exp_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'd0);
          else if (out_ready) begin
            check("product", out_data, exp_q.pop_front());
            hs_count++;
            hs_times.push_back(cyc);
          end
        end
        held = out_valid && !out_ready;
        held_data = out_data;
      end
      prev_ops = ops_done;
    end
  end

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 32'h0;
    in_b = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_data", out_data, 64'h0);
    check("rst_mul_a", 64'(mul_a), 64'h0);
    check("rst_mul_b", 64'(mul_b), 64'h0);
    check("rst_mul_enable", 64'(mul_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Single op: latency from acceptance edge and one-cycle valid.
    push(32'd3, 32'd5);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    check("latency", 64'(lat), 64'(LAT + 3));
    check("first_product", out_data, 64'h0F);
    tick();
    @(negedge clk);
    check("valid_one_cycle", 64'(out_valid), 64'd0);
    check("ops_done_one", 64'(ops_done), 64'd1);
    tick();

    // Extreme operands.
    push(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid("max_seen");
    check("max_product", out_data, 64'hFFFFFFFE00000001);
    tick();
    push(32'hFFFF0000, 32'h0000FFFF);
    wait_valid("mixed_seen");
    check("mixed_product", out_data, 64'h0000FFFE00010000);
    tick();
    drain();

    // Back-to-back burst: FIFO fills, products in order at the minimum issue interval.
    hs_times.delete();
    stalled = 1'b0;
    push(32'd11, 32'd13);
    push(32'd17, 32'd19);
    push(32'd23, 32'd29);
    push(32'd31, 32'd37);
    drain();
    check("burst_stall", 64'(stalled), 64'd1);
    check("burst_count", 64'(hs_times.size()), 64'd4);
    for (int i = 1; i < hs_times.size(); i++)
      check("burst_interval", 64'(hs_times[i] - hs_times[i-1]), 64'(LAT + 3));

    // Back-pressure: first product held stable, second waits until released.
    out_ready = 1'b0;
    push(32'd7, 32'd9);
    push(32'h00010000, 32'h00010000);
    wait_valid("bp_seen");
    repeat (20) begin
      tick();
      @(negedge clk);
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_data", out_data, 64'd63);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    wait_valid("bp_second_seen");
    check("bp_second", out_data, 64'h0000000100000000);
    tick();
    drain();

    // Reset while the multiplier is running discards the op.
    push(32'h1234, 32'h5678);
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mul_rst", 64'(mul_rst), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    push(32'hDEADBEEF, 32'hCAFEF00D);
    wait_valid("post_rst_seen");
    check("post_rst_product", out_data, 64'(32'hDEADBEEF) * 64'(32'hCAFEF00D));
    tick();
    drain();

    // Random operands under random back-pressure; enough hand-offs to wrap ops_done.
    rand_bp = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      push(ra, rb);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    check("wrap_count_enough", 64'(hs_count >= 17), 64'd1);
    check("ops_done_wrapped", 64'(saw_wrap), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
